// File: rtl/nn_inference_scheduler.sv
// rtl/nn_inference_scheduler.sv - frame-synchronised inference sequencer with watchdog and argmax scan
module nn_inference_scheduler #(
  parameter int NUM_CLASSES    = 10,
  parameter int PROB_W         = 16,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Frame_tick,
  input  logic                          Canvas_edit,
  input  logic                          Force,
  input  logic                          Nn_ready,
  input  logic [NUM_CLASSES*PROB_W-1:0] Probability,
  output logic                          Nn_start,
  output logic                          Busy,
  output logic                          Result_valid,
  output logic                          Result_pulse,
  output logic [IDX_W-1:0]              Argmax,
  output logic [PROB_W-1:0]             Max_prob,
  output logic                          Timeout
);

  localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_SCAN, S_DONE
  } state_t;

  state_t state, state_next;

  logic              pending;
  logic [WD_W-1:0]   wd_cnt;
  logic [PROB_W-1:0] snap [NUM_CLASSES];
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  run_idx;
  logic [PROB_W-1:0] run_max;
  logic [PROB_W-1:0] cur_prob;
  logic              wd_expired;
  logic              timeout_hit;
  logic              capture;
  logic              set_evt;
  logic              take;

  always_comb begin
    wd_expired  = (wd_cnt >= WD_LAST);
    cur_prob    = snap[scan_idx];
    // Index 0 seeds the running max; strict '>' keeps the lowest index on ties.
    take        = (scan_idx == '0) || (cur_prob > run_max);
    set_evt     = (state != S_IDLE) && (Canvas_edit || (Force && (state != S_ARM)));
    timeout_hit = 1'b0;
    capture     = 1'b0;
    state_next  = state;

    case (state)
      S_IDLE: begin
        if (Force)            state_next = S_START;
        else if (Canvas_edit) state_next = S_ARM;
      end
      S_ARM: begin
        if (Force || Frame_tick) state_next = S_START;
      end
      S_START: state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!Nn_ready) begin
          state_next = S_WAIT_DONE;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (Nn_ready) begin
          capture    = 1'b1;
          state_next = S_SCAN;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_SCAN: begin
        if (scan_idx == LAST_IDX) state_next = S_DONE;
      end
      S_DONE: state_next = (pending || set_evt) ? S_ARM : S_IDLE;
      default: state_next = S_IDLE;
    endcase

    Nn_start     = (state == S_START);
    Busy         = (state != S_IDLE);
    Result_pulse = (state == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      wd_cnt       <= '0;
      scan_idx     <= '0;
      run_idx      <= '0;
      run_max      <= '0;
      Argmax       <= '0;
      Max_prob     <= '0;
      Result_valid <= 1'b0;
      Timeout      <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
    end else begin
      state <= state_next;

      // An edit landing in the START cycle may be missed by the network, so it survives the clear.
      if (state == S_START) pending <= set_evt;
      else if (set_evt)     pending <= 1'b1;

      if (state == S_START)
        wd_cnt <= '0;
      else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
        wd_cnt <= wd_cnt + WD_W'(1);

      if (timeout_hit) Timeout <= 1'b1;

      if (capture) begin
        for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= Probability[i*PROB_W +: PROB_W];
        scan_idx <= '0;
      end

      if (state == S_SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (take) begin
          run_max <= cur_prob;
          run_idx <= scan_idx;
        end
        // Publish on the last class so the outputs are stable throughout the DONE cycle.
        if (scan_idx == LAST_IDX) begin
          Argmax       <= take ? scan_idx : run_idx;
          Max_prob     <= take ? cur_prob : run_max;
          Result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_inference_scheduler.sv
// tb/tb_nn_inference_scheduler.sv - vector table, corner sequences and randomized runs for nn_inference_scheduler
module tb_nn_inference_scheduler;

  localparam int NC = 10;
  localparam int PW = 16;
  localparam int IW = 4;

  typedef struct {
    logic [NC*PW-1:0] pv;
    logic [IW-1:0]    am;
    logic [PW-1:0]    mp;
  } vec_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Reset_n, Frame_tick, Canvas_edit, Force, Nn_ready, wd_ready;
  logic [NC*PW-1:0] Probability;
  logic             Nn_start, Busy, Result_valid, Result_pulse, Timeout;
  logic [IW-1:0]    Argmax;
  logic [PW-1:0]    Max_prob;
  logic             wd_start, wd_busy, wd_valid, wd_pulse, wd_timeout;
  logic [IW-1:0]    wd_argmax;
  logic [PW-1:0]    wd_max;

  nn_inference_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Canvas_edit(Canvas_edit),
    .Force(Force), .Nn_ready(Nn_ready), .Probability(Probability),
    .Nn_start(Nn_start), .Busy(Busy), .Result_valid(Result_valid),
    .Result_pulse(Result_pulse), .Argmax(Argmax), .Max_prob(Max_prob), .Timeout(Timeout)
  );

  nn_inference_scheduler #(.TIMEOUT_CYCLES(50)) dut_wd (
    .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Canvas_edit(Canvas_edit),
    .Force(Force), .Nn_ready(wd_ready), .Probability(Probability),
    .Nn_start(wd_start), .Busy(wd_busy), .Result_valid(wd_valid),
    .Result_pulse(wd_pulse), .Argmax(wd_argmax), .Max_prob(wd_max), .Timeout(wd_timeout)
  );

  int   n_pass = 0;
  int   n_chk  = 0;
  logic prev_start = 1'b0;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    if (Nn_start) chk("start_not_back_to_back", 32'(prev_start), 0);
    prev_start = Nn_start;
  endtask

  function automatic logic [NC*PW-1:0] mk(input logic [PW-1:0] fill, input int i1,
                                          input logic [PW-1:0] v1, input int i2,
                                          input logic [PW-1:0] v2);
    logic [NC*PW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*PW +: PW] = fill;
    r[i1*PW +: PW] = v1;
    r[i2*PW +: PW] = v2;
    return r;
  endfunction

  function automatic logic [NC*PW-1:0] rnd_vec(input int unsigned maxv);
    logic [NC*PW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*PW +: PW] = PW'($urandom_range(0, maxv));
    return r;
  endfunction

  // Reference: first index holding the largest value.
  function automatic logic [IW+PW-1:0] ref_best(input logic [NC*PW-1:0] pv);
    int best = 0;
    for (int i = 1; i < NC; i++)
      if (pv[i*PW +: PW] > pv[best*PW +: PW]) best = i;
    return {IW'(best), pv[best*PW +: PW]};
  endfunction

  task automatic trigger(input bit use_force, input string tag);
    if (use_force) Force = 1'b1;
    else           Frame_tick = 1'b1;
    cyc();
    Force = 1'b0;
    Frame_tick = 1'b0;
    chk({tag, "_start"}, 32'(Nn_start), 1);
    cyc();
    chk({tag, "_start_once"}, 32'(Nn_start), 0);
    chk({tag, "_busy"}, 32'(Busy), 1);
  endtask

  task automatic complete_run(input logic [NC*PW-1:0] pv, input int drop_dly, input int wait_len,
                              input int n_edits, input int n_forces,
                              output logic [IW-1:0] am, output logic [PW-1:0] mp, output int lat);
    repeat (drop_dly) cyc();
    Nn_ready = 1'b0;
    Probability = rnd_vec(16'hFFFF);
    for (int i = 0; i < wait_len; i++) begin
      Canvas_edit = (i < n_edits);
      Force = (i >= n_edits) && (i < n_edits + n_forces);
      Frame_tick = 1'($urandom_range(0, 1));
      cyc();
    end
    Canvas_edit = 1'b0;
    Force = 1'b0;
    Frame_tick = 1'b0;
    Probability = pv;
    Nn_ready = 1'b1;
    cyc();
    Probability = rnd_vec(16'hFFFF);
    lat = 1;
    while (!Result_pulse && lat < 60) begin
      cyc();
      lat++;
    end
    am = Argmax;
    mp = Max_prob;
  endtask

  task automatic post(input bit exp_arm, input string tag);
    cyc();
    chk({tag, "_pulse_one_cycle"}, 32'(Result_pulse), 0);
    chk({tag, "_armed"}, 32'(Busy), 32'(exp_arm));
  endtask

  initial begin
    logic [IW-1:0]    am;
    logic [PW-1:0]    mp;
    logic [IW+PW-1:0] best;
    logic [NC*PW-1:0] pv;
    int lat, starts, n, ne, nf;
    bit armed;

    tbl[0] = '{mk(16'h0010, 9, 16'h0100, 7, 16'h7F00), 4'd7, 16'h7F00};
    tbl[1] = '{mk(16'h0000, 2, 16'hFFFF, 5, 16'hFFFF), 4'd2, 16'hFFFF};
    tbl[2] = '{mk(16'h0000, 0, 16'h0000, 0, 16'h0000), 4'd0, 16'h0000};
    tbl[3] = '{mk(16'h0001, 9, 16'hFFFF, 9, 16'hFFFF), 4'd9, 16'hFFFF};
    tbl[4] = '{mk(16'h1234, 0, 16'h1234, 0, 16'h1234), 4'd0, 16'h1234};
    tbl[5] = '{mk(16'h0005, 3, 16'h8000, 4, 16'h7FFF), 4'd3, 16'h8000};
    tbl[6] = '{mk(16'h00FF, 0, 16'hFFFE, 8, 16'hFFFE), 4'd0, 16'hFFFE};
    tbl[7] = '{mk(16'h0100, 6, 16'h0101, 1, 16'h0001), 4'd6, 16'h0101};

    Reset_n = 1'b0; Frame_tick = 1'b0; Canvas_edit = 1'b0; Force = 1'b0;
    Nn_ready = 1'b1; wd_ready = 1'b1; Probability = '0;
    repeat (3) cyc();
    chk("reset_outputs", 32'({Nn_start, Busy, Result_valid, Result_pulse, Timeout, Argmax, Max_prob}), 0);
    Reset_n = 1'b1;
    repeat (3) cyc();

    Frame_tick = 1'b1;
    cyc();
    Frame_tick = 1'b0;
    chk("frame_alone_idle", 32'(Busy), 0);
    cyc();

    for (int k = 0; k < 8; k++) begin
      trigger(1'b1, "vec");
      complete_run(tbl[k].pv, (k == 0) ? 2 : k % 4, (k == 0) ? 100 : 5 + k, 0, 0, am, mp, lat);
      chk($sformatf("vec%0d_argmax", k), 32'(am), 32'(tbl[k].am));
      chk($sformatf("vec%0d_max_prob", k), 32'(mp), 32'(tbl[k].mp));
      chk($sformatf("vec%0d_latency", k), 32'(lat), 11);
      chk($sformatf("vec%0d_valid", k), 32'(Result_valid), 1);
      post(1'b0, "vec");
    end

    Canvas_edit = 1'b1;
    Frame_tick = 1'b1;
    cyc();
    Canvas_edit = 1'b0;
    Frame_tick = 1'b0;
    chk("edit_frame_same_cycle_start", 32'(Nn_start), 0);
    chk("edit_enters_arm", 32'(Busy), 1);
    starts = 0;
    repeat (5) begin
      cyc();
      starts += int'(Nn_start);
    end
    chk("arm_waits_for_frame", 32'(starts), 0);
    trigger(1'b0, "frame_after_edit");
    complete_run(tbl[1].pv, 1, 6, 0, 0, am, mp, lat);
    chk("frame_run_argmax", 32'(am), 2);
    post(1'b0, "frame_run");

    trigger(1'b1, "coalesce");
    complete_run(tbl[5].pv, 1, 10, 3, 0, am, mp, lat);
    chk("coalesce_argmax", 32'(am), 3);
    post(1'b1, "coalesce");
    starts = 0;
    repeat (4) begin
      cyc();
      starts += int'(Nn_start);
    end
    chk("coalesce_no_start_before_frame", 32'(starts), 0);
    trigger(1'b0, "coalesce_follow");
    complete_run(tbl[3].pv, 0, 4, 0, 0, am, mp, lat);
    chk("coalesce_follow_argmax", 32'(am), 9);
    post(1'b0, "coalesce_follow");

    armed = 1'b0;
    for (int it = 0; it < 30; it++) begin
      pv = (it % 2 == 0) ? rnd_vec(3) : rnd_vec(16'hFFFF);
      if (armed) begin
        repeat ($urandom_range(0, 3)) begin
          cyc();
          chk("rnd_armed_hold", 32'(Nn_start), 0);
        end
        trigger(1'($urandom_range(0, 1)), "rnd_armed");
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          Frame_tick = 1'b1;
          cyc();
          Frame_tick = 1'b0;
          chk("rnd_idle_frame", 32'(Busy), 0);
        end
        trigger(1'b1, "rnd");
      end
      ne = $urandom_range(0, 2);
      nf = $urandom_range(0, 1);
      complete_run(pv, $urandom_range(0, 4), $urandom_range(ne + nf + 1, 20), ne, nf, am, mp, lat);
      best = ref_best(pv);
      chk($sformatf("rnd%0d_argmax", it), 32'(am), 32'(best[IW+PW-1:PW]));
      chk($sformatf("rnd%0d_max_prob", it), 32'(mp), 32'(best[PW-1:0]));
      chk($sformatf("rnd%0d_latency", it), 32'(lat), 11);
      armed = (ne + nf) > 0;
      post(armed, $sformatf("rnd%0d", it));
    end

    Reset_n = 1'b0;
    repeat (2) cyc();
    Reset_n = 1'b1;
    Force = 1'b1;
    cyc();
    Force = 1'b0;
    chk("wd_prime_start", 32'(wd_start), 1);
    wd_ready = 1'b0;
    repeat (3) cyc();
    Probability = tbl[0].pv;
    wd_ready = 1'b1;
    cyc();
    Probability = rnd_vec(16'hFFFF);
    n = 1;
    while (!wd_pulse && n < 60) begin
      cyc();
      n++;
    end
    chk("wd_prime_argmax", 32'(wd_argmax), 7);
    chk("wd_prime_max_prob", 32'(wd_max), 'h7F00);
    cyc();
    chk("wd_prime_idle", 32'(wd_busy), 0);
    chk("wd_prime_no_timeout", 32'(wd_timeout), 0);
    Force = 1'b1;
    cyc();
    Force = 1'b0;
    chk("wd_stuck_start", 32'(wd_start), 1);
    wd_ready = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (wd_busy && n < 200);
    chk("wd_cycles_to_idle", 32'(n), 51);
    chk("wd_timeout_set", 32'(wd_timeout), 1);
    chk("wd_argmax_kept", 32'(wd_argmax), 7);
    chk("wd_max_prob_kept", 32'(wd_max), 'h7F00);
    chk("wd_valid_kept", 32'(wd_valid), 1);
    wd_ready = 1'b1;

    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    cyc();
    trigger(1'b1, "pre_reset");
    complete_run(tbl[0].pv, 1, 5, 0, 0, am, mp, lat);
    chk("pre_reset_argmax", 32'(am), 7);
    post(1'b0, "pre_reset");
    trigger(1'b1, "mid_reset");
    Nn_ready = 1'b0;
    repeat (4) cyc();
    chk("mid_reset_busy_before", 32'(Busy), 1);
    Reset_n = 1'b0;
    cyc();
    chk("mid_reset_outputs", 32'({Nn_start, Busy, Result_valid, Result_pulse, Timeout, Argmax, Max_prob}), 0);
    Reset_n = 1'b1;
    Nn_ready = 1'b1;
    starts = 0;
    repeat (6) begin
      Frame_tick = 1'b1;
      cyc();
      starts += int'(Nn_start);
    end
    Frame_tick = 1'b0;
    chk("mid_reset_needs_trigger", 32'(starts), 0);
    chk("mid_reset_idle", 32'(Busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
